// File: rtl/branch_rs_queue.sv
// Reservation-station queue for conditional branches: captures operands from the CDB,
// resolves the oldest ready branch each cycle and reports taken/not-taken with its ROB tag.
module branch_rs_queue #(
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned RB_INDEX  = 4,
  parameter int unsigned RB_SIZE   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic [1:0]                        issue_op,
  input  logic [RB_INDEX-1:0]               issue_dest,
  input  logic [WORD_SIZE-1:0]              issue_vj,
  input  logic [WORD_SIZE-1:0]              issue_vk,
  input  logic [RB_INDEX-1:0]               issue_qj,
  input  logic [RB_INDEX-1:0]               issue_qk,
  input  logic                              issue_rj,
  input  logic                              issue_rk,
  input  logic [WORD_SIZE*RB_SIZE-1:0]      cdb_data,
  input  logic [RB_SIZE-1:0]                cdb_valid,
  output logic                              result_valid,
  output logic                              result_taken,
  output logic [RB_INDEX-1:0]               result_dest,
  output logic [$clog2(ENTRIES+1)-1:0]      count
);

  localparam int unsigned CW = $clog2(ENTRIES + 1);
  localparam int unsigned AW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]   busy_q, rj_q, rk_q;
  logic [1:0]           op_q   [ENTRIES];
  logic [RB_INDEX-1:0]  dest_q [ENTRIES];
  logic [RB_INDEX-1:0]  qj_q   [ENTRIES];
  logic [RB_INDEX-1:0]  qk_q   [ENTRIES];
  logic [WORD_SIZE-1:0] vj_q   [ENTRIES];
  logic [WORD_SIZE-1:0] vk_q   [ENTRIES];
  // Age is a rank among busy entries: 0 is the oldest, ranks are always dense.
  logic [AW-1:0]        age_q  [ENTRIES];
  logic [CW-1:0]        count_q;

  logic [WORD_SIZE-1:0] cdb_word [RB_SIZE];
  for (genvar t = 0; t < RB_SIZE; t++) begin : g_cdb
    assign cdb_word[t] = cdb_data[t*WORD_SIZE +: WORD_SIZE];
  end

  logic          disp_found, do_disp, do_issue;
  logic [AW-1:0] disp_idx, disp_age, free_idx;

  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    disp_age   = '0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = AW'(i);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && rj_q[i] && rk_q[i] && (!disp_found || age_q[i] < disp_age)) begin
        disp_found = 1'b1;
        disp_idx   = AW'(i);
        disp_age   = age_q[i];
      end
    end
  end

  assign count       = count_q;
  assign issue_ready = count_q < CW'(ENTRIES);
  assign do_issue    = issue_valid && issue_ready && !flush;
  assign do_disp     = disp_found && !flush;

  function automatic logic branch_cmp(input logic [1:0] op, input logic [WORD_SIZE-1:0] a,
                                      input logic [WORD_SIZE-1:0] b);
    unique case (op)
      2'b00:   return a == b;
      2'b01:   return a != b;
      2'b10:   return $signed(a) < $signed(b);
      default: return $signed(a) >= $signed(b);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      rj_q         <= '0;
      rk_q         <= '0;
      count_q      <= '0;
      result_valid <= 1'b0;
      result_taken <= 1'b0;
      result_dest  <= '1;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      result_taken <= 1'b0;
      result_dest  <= '1;
      if (flush) begin
        busy_q  <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (busy_q[i] && !rj_q[i] && cdb_valid[qj_q[i]]) begin
            vj_q[i] <= cdb_word[qj_q[i]];
            rj_q[i] <= 1'b1;
          end
          if (busy_q[i] && !rk_q[i] && cdb_valid[qk_q[i]]) begin
            vk_q[i] <= cdb_word[qk_q[i]];
            rk_q[i] <= 1'b1;
          end
          if (do_disp && busy_q[i] && age_q[i] > disp_age) age_q[i] <= age_q[i] - AW'(1);
        end
        if (do_disp) begin
          busy_q[disp_idx] <= 1'b0;
          result_valid     <= 1'b1;
          result_taken     <= branch_cmp(op_q[disp_idx], vj_q[disp_idx], vk_q[disp_idx]);
          result_dest      <= dest_q[disp_idx];
        end
        // Free slot comes from registered busy bits, so it never collides with dispatch.
        if (do_issue) begin
          busy_q[free_idx] <= 1'b1;
          op_q[free_idx]   <= issue_op;
          dest_q[free_idx] <= issue_dest;
          qj_q[free_idx]   <= issue_qj;
          qk_q[free_idx]   <= issue_qk;
          vj_q[free_idx]   <= issue_rj ? issue_vj : cdb_word[issue_qj];
          vk_q[free_idx]   <= issue_rk ? issue_vk : cdb_word[issue_qk];
          rj_q[free_idx]   <= issue_rj | cdb_valid[issue_qj];
          rk_q[free_idx]   <= issue_rk | cdb_valid[issue_qk];
          age_q[free_idx]  <= do_disp ? AW'(count_q - CW'(1)) : AW'(count_q);
        end
        count_q <= count_q + CW'(do_issue) - CW'(do_disp);
      end
    end
  end

endmodule

// File: tb/tb_branch_rs_queue.sv
// Directed bench for branch_rs_queue; a negedge monitor checks every result pulse
// against a scoreboard of expected {taken, dest} pairs.
module tb_branch_rs_queue;

  localparam int ENTRIES = 4, WORD_SIZE = 32, RB_INDEX = 4, RB_SIZE = 16;
  localparam logic [1:0] BEQ = 2'b00, BNE = 2'b01, BLT = 2'b10, BGE = 2'b11;

  logic                         clk, reset, flush, issue_valid, issue_ready;
  logic [1:0]                   issue_op;
  logic [RB_INDEX-1:0]          issue_dest, issue_qj, issue_qk;
  logic [WORD_SIZE-1:0]         issue_vj, issue_vk;
  logic                         issue_rj, issue_rk;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data;
  logic [RB_SIZE-1:0]           cdb_valid;
  logic                         result_valid, result_taken;
  logic [RB_INDEX-1:0]          result_dest;
  logic [2:0]                   count;

  branch_rs_queue #(
    .ENTRIES(ENTRIES), .WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX), .RB_SIZE(RB_SIZE)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rj(issue_rj), .issue_rk(issue_rk), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .result_valid(result_valid), .result_taken(result_taken), .result_dest(result_dest),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] sb[$];
  logic [4:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] dest, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                       input logic rj, input logic rk);
    issue_op = op; issue_dest = dest; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk; issue_rj = rj; issue_rk = rk;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic cdb(input int t, input logic [31:0] d);
    cdb_valid[t] = 1'b1;
    cdb_data[t*WORD_SIZE +: WORD_SIZE] = d;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 20 && (sb.size() != 0 || count != 0); n++) tick();
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_count"}, count, 0);
  endtask

  // Every result pulse must match the scoreboard head; idle cycles must show NULL/0.
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("FAIL unexpected_result observed dest=%0h expected no pulse", result_dest);
        end else begin
          mon_exp = sb.pop_front();
          assert ({result_taken, result_dest} === mon_exp) else begin
            errors++;
            $error("FAIL result observed=%0h expected=%0h", {result_taken, result_dest}, mon_exp);
          end
        end
      end else begin
        checks++;
        assert ({result_taken, result_dest} === 5'h0F) else begin
          errors++;
          $error("FAIL idle_outputs observed=%0h expected=0f", {result_taken, result_dest});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_dest = '0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0; issue_rj = 1'b0; issue_rk = 1'b0;
    cdb_data = '0; cdb_valid = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_valid", result_valid, 0);
    chk("rst_dest", result_dest, 4'hF);
    chk("rst_taken", result_taken, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // Minimum latency, BGE equal operands
    sb.push_back({1'b1, 4'd3});
    issue(BGE, 4'd3, 32'd5, 32'd5, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t1_count", count, 1);
    chk("t1_not_yet", result_valid, 0);
    tick();
    chk("t1_valid", result_valid, 1);
    chk("t1_taken", result_taken, 1);
    chk("t1_dest", result_dest, 3);
    chk("t1_count_after", count, 0);
    tick();
    chk("t1_pulse_end", result_valid, 0);

    // Signed BLT and BNE on equal operands
    sb.push_back({1'b1, 4'd5});
    issue(BLT, 4'd5, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    sb.push_back({1'b0, 4'd6});
    issue(BNE, 4'd6, 32'd7, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t2_blt_dest", result_dest, 5);
    chk("t2_blt_taken", result_taken, 1);
    tick();
    chk("t2_bne_dest", result_dest, 6);
    chk("t2_bne_taken", result_taken, 0);
    drain("t2");

    // Waiting operand woken by the CDB
    sb.push_back({1'b1, 4'd7});
    issue(BEQ, 4'd7, 32'd0, 32'd9, 4'd6, 4'd0, 1'b0, 1'b1);
    tick();
    cdb(6, 32'd9);
    tick();
    cdb_valid = '0;
    chk("t3_no_early", result_valid, 0);
    tick();
    chk("t3_valid", result_valid, 1);
    chk("t3_dest", result_dest, 7);
    drain("t3");

    // Fill the queue; release two tags at once; reuse a freed slot
    issue(BEQ, 4'd8, 32'd0, 32'd0, 4'd10, 4'd0, 1'b0, 1'b1);
    issue(BEQ, 4'd9, 32'd0, 32'd0, 4'd11, 4'd0, 1'b0, 1'b1);
    issue(BEQ, 4'd10, 32'd0, 32'd0, 4'd12, 4'd0, 1'b0, 1'b1);
    issue(BEQ, 4'd11, 32'd0, 32'd0, 4'd13, 4'd0, 1'b0, 1'b1);
    chk("t4_full_count", count, 4);
    chk("t4_full_ready", issue_ready, 0);
    issue(BEQ, 4'd15, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t4_full_reject", count, 4);
    sb.push_back({1'b1, 4'd9});
    sb.push_back({1'b1, 4'd11});
    cdb(13, 32'd0);
    cdb(11, 32'd0);
    tick();
    cdb_valid = '0;
    chk("t4_capture_wait", result_valid, 0);
    tick();
    chk("t4_older_first", result_dest, 9);
    tick();
    chk("t4_younger_next", result_dest, 11);
    chk("t4_count2", count, 2);
    issue(BEQ, 4'd12, 32'd0, 32'd0, 4'd14, 4'd0, 1'b0, 1'b1);
    chk("t4_reuse_count", count, 3);
    sb.push_back({1'b0, 4'd8});
    sb.push_back({1'b0, 4'd10});
    sb.push_back({1'b1, 4'd12});
    cdb(10, 32'd1);
    cdb(12, 32'd1);
    cdb(14, 32'd0);
    tick();
    cdb_valid = '0;
    tick();
    chk("t4_age0", result_dest, 8);
    tick();
    chk("t4_age1", result_dest, 10);
    tick();
    chk("t4_age2_reused", result_dest, 12);
    drain("t4");

    // Bypass from the CDB in the issue cycle
    sb.push_back({1'b1, 4'd13});
    cdb(2, 32'd4);
    issue(BEQ, 4'd13, 32'd0, 32'd4, 4'd2, 4'd0, 1'b0, 1'b1);
    cdb_valid = '0;
    chk("t5_count", count, 1);
    tick();
    chk("t5_bypass_valid", result_valid, 1);
    chk("t5_bypass_dest", result_dest, 13);
    drain("t5");

    // Flush clears entries, suppresses issue and dispatch
    issue(BEQ, 4'd1, 32'd0, 32'd0, 4'd5, 4'd0, 1'b0, 1'b1);
    issue(BEQ, 4'd2, 32'd0, 32'd0, 4'd6, 4'd0, 1'b0, 1'b1);
    chk("t6_count2", count, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_valid", result_valid, 0);
    issue(BEQ, 4'd3, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    issue_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("t6_flush_beats_issue", count, 0);
    chk("t6_no_dispatch", result_valid, 0);
    cdb(5, 32'd0);
    cdb(6, 32'd0);
    tick();
    cdb_valid = '0;
    tick();
    tick();
    chk("t6_dropped", count, 0);

    // Asynchronous reset while a pulse is live and an entry is waiting
    issue(BEQ, 4'd4, 32'd0, 32'd0, 4'd5, 4'd0, 1'b0, 1'b1);
    issue(BGE, 4'd5, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    tick();
    chk("t7_pre_valid", result_valid, 1);
    reset = 1'b1;
    #1;
    chk("t7_rst_count", count, 0);
    chk("t7_rst_ready", issue_ready, 1);
    chk("t7_rst_valid", result_valid, 0);
    chk("t7_rst_dest", result_dest, 4'hF);
    chk("t7_rst_taken", result_taken, 0);
    @(negedge clk) reset = 1'b0;
    sb.push_back({1'b0, 4'd7});
    cdb(5, 32'd0);
    issue(BNE, 4'd7, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    cdb_valid = '0;
    chk("t7_first_issue", count, 1);
    tick();
    chk("t7_after_valid", result_valid, 1);
    chk("t7_after_dest", result_dest, 7);
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
